// File: rtl/eel_rst_seq.sv
// Reset/run sequencer: synchronises the board reset, holds every channel, releases channels
// one by one in ascending order, and optionally halts the system after a fixed run length.
module eel_rst_seq #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned STAGGER     = 4,
    parameter int unsigned RUN_CYCLES  = 30,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST,
    output logic [NUM_CH-1:0] CH_RST,
    output logic              READY,
    output logic              RUN_DONE,
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(STAGGER * (NUM_CH - 32'd1));
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'((RUN_CYCLES == 32'd0) ? 32'd0 : RUN_CYCLES - 32'd1);
    localparam bit               WDOG_EN   = (RUN_CYCLES != 32'd0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [NUM_CH-1:0]      ch_d;
    logic                   ready_d;
    logic                   done_d;

    // Release-side synchroniser; assertion is asynchronous through RST on every flop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // Next-state and next-output logic; SW_RST outranks every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = CH_RST;
        ready_d = READY;
        done_d  = RUN_DONE;

        if ((state_q != S_RESET) && SW_RST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            ch_d    = '1;
            ready_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    cnt_d = '0;
                    if (rst_sync) begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (cnt_q == CNT_W'(STAGGER * i)) begin
                            ch_d[i] = 1'b0;
                        end
                    end
                    if (cnt_q == REL_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (WDOG_EN) begin
                        if (cnt_q == RUN_LAST) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                            ch_d    = '1;
                            ready_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                    ch_d    = '1;
                    ready_d = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_RESET;
            cnt_q    <= '0;
            CH_RST   <= '1;
            READY    <= 1'b0;
            RUN_DONE <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            CH_RST   <= ch_d;
            READY    <= ready_d;
            RUN_DONE <= done_d;
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_eel_rst_seq.sv
// Bench for eel_rst_seq: default 4-channel instance driven from timeline tables, plus a
// single-channel, watchdog-disabled instance.
module tb_eel_rst_seq;

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_HOLD    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_RUN     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    typedef struct {
        logic       sw;
        logic [2:0] st;
        logic [3:0] ch;
        logic       rdy;
        logic       dn;
    } vec_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       sw_rst = 1'b0;
    logic [3:0] ch_a;
    logic       rdy_a;
    logic       dn_a;
    logic [2:0] st_a;

    logic       rst_b  = 1'b1;
    logic       sw_b   = 1'b0;
    logic [0:0] ch_b;
    logic       rdy_b;
    logic       dn_b;
    logic [2:0] st_b;

    int checks = 0;
    int errors = 0;

    vec_t pwr_tab[$];
    vec_t sw_tab[$];
    vec_t sb_q[$];

    eel_rst_seq dut_a (
        .CLK      (clk),
        .RST      (rst),
        .SW_RST   (sw_rst),
        .CH_RST   (ch_a),
        .READY    (rdy_a),
        .RUN_DONE (dn_a),
        .STATE    (st_a)
    );

    eel_rst_seq #(.NUM_CH(1), .RUN_CYCLES(0)) dut_b (
        .CLK      (clk),
        .RST      (rst_b),
        .SW_RST   (sw_b),
        .CH_RST   (ch_b),
        .READY    (rdy_b),
        .RUN_DONE (dn_b),
        .STATE    (st_b)
    );

    always #5 clk = ~clk;

    function automatic void add(input int which, input int n, input logic sw, input logic [2:0] st,
                                input logic [3:0] ch, input logic rdy, input logic dn);
        vec_t v;
        v.sw  = sw;
        v.st  = st;
        v.ch  = ch;
        v.rdy = rdy;
        v.dn  = dn;
        for (int k = 0; k < n; k++) begin
            if (which == 0) pwr_tab.push_back(v);
            else            sw_tab.push_back(v);
        end
    endfunction

    task automatic check_a(input string name, input int idx, input vec_t e);
        checks++;
        if (st_a !== e.st || ch_a !== e.ch || rdy_a !== e.rdy || dn_a !== e.dn) begin
            errors++;
            $display("FAIL %s[%0d] got st=%0d ch=%h rdy=%b dn=%b want st=%0d ch=%h rdy=%b dn=%b",
                     name, idx, st_a, ch_a, rdy_a, dn_a, e.st, e.ch, e.rdy, e.dn);
        end
    endtask

    task automatic check_b(input string name, input logic [2:0] st, input logic ch, input logic rdy);
        checks++;
        if (st_b !== st || ch_b[0] !== ch || rdy_b !== rdy || dn_b !== 1'b0) begin
            errors++;
            $display("FAIL %s got st=%0d ch=%b rdy=%b dn=%b want st=%0d ch=%b rdy=%b dn=0",
                     name, st_b, ch_b[0], rdy_b, dn_b, st, ch, rdy);
        end
    endtask

    // Drive one table row per clock; expectation goes through the scoreboard queue.
    task automatic run_tab(input int which, input string name);
        int   n;
        vec_t v;
        vec_t e;
        n = (which == 0) ? pwr_tab.size() : sw_tab.size();
        for (int i = 0; i < n; i++) begin
            v = (which == 0) ? pwr_tab[i] : sw_tab[i];
            @(negedge clk);
            sw_rst = v.sw;
            sb_q.push_back(v);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check_a(name, i, e);
        end
        sw_rst = 1'b0;
    endtask

    initial begin
        vec_t rv;
        rv.sw = 1'b0; rv.st = S_RESET; rv.ch = 4'hF; rv.rdy = 1'b0; rv.dn = 1'b0;

        // Power-on timeline, one row per edge from E1; SW_RST is raised on E1-E2 and must be ignored.
        add(0, 2,  1'b1, S_RESET,   4'hF, 1'b0, 1'b0);
        add(0, 8,  1'b0, S_HOLD,    4'hF, 1'b0, 1'b0);
        add(0, 1,  1'b0, S_RELEASE, 4'hF, 1'b0, 1'b0);
        add(0, 4,  1'b0, S_RELEASE, 4'hE, 1'b0, 1'b0);
        add(0, 4,  1'b0, S_RELEASE, 4'hC, 1'b0, 1'b0);
        add(0, 4,  1'b0, S_RELEASE, 4'h8, 1'b0, 1'b0);
        add(0, 1,  1'b0, S_RUN,     4'h0, 1'b1, 1'b0);
        add(0, 29, 1'b0, S_RUN,     4'h0, 1'b1, 1'b0);
        add(0, 1,  1'b0, S_DONE,    4'hF, 1'b0, 1'b1);
        add(0, 5,  1'b0, S_DONE,    4'hF, 1'b0, 1'b1);

        // From DONE: SW_RST held 3 edges, full re-sequence, then a 1-cycle pulse mid-RELEASE.
        add(1, 3,  1'b1, S_HOLD,    4'hF, 1'b0, 1'b0);
        add(1, 7,  1'b0, S_HOLD,    4'hF, 1'b0, 1'b0);
        add(1, 1,  1'b0, S_RELEASE, 4'hF, 1'b0, 1'b0);
        add(1, 4,  1'b0, S_RELEASE, 4'hE, 1'b0, 1'b0);
        add(1, 2,  1'b0, S_RELEASE, 4'hC, 1'b0, 1'b0);
        add(1, 1,  1'b1, S_HOLD,    4'hF, 1'b0, 1'b0);
        add(1, 7,  1'b0, S_HOLD,    4'hF, 1'b0, 1'b0);
        add(1, 1,  1'b0, S_RELEASE, 4'hF, 1'b0, 1'b0);
        add(1, 4,  1'b0, S_RELEASE, 4'hE, 1'b0, 1'b0);
        add(1, 4,  1'b0, S_RELEASE, 4'hC, 1'b0, 1'b0);
        add(1, 4,  1'b0, S_RELEASE, 4'h8, 1'b0, 1'b0);
        add(1, 1,  1'b0, S_RUN,     4'h0, 1'b1, 1'b0);
        add(1, 10, 1'b0, S_RUN,     4'h0, 1'b1, 1'b0);

        #2;
        rst   = 1'b0;
        rst_b = 1'b0;
        #1;
        check_a("reset_async", 0, rv);
        check_b("b_reset", S_RESET, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_a("reset_hold", i, rv);
        end
        rst = 1'b1;
        run_tab(0, "pwr_on");
        run_tab(1, "sw_rst");

        // Asynchronous reset between edges while in RUN.
        #2;
        rst = 1'b0;
        #1;
        check_a("rst_mid_run", 0, rv);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_a("rst_mid_hold", i, rv);
        end
        rst = 1'b1;
        run_tab(0, "pwr_again");

        // Single channel, watchdog disabled.
        rst_b = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_b("b_hold_e10", S_HOLD, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_b("b_release_e11", S_RELEASE, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_b("b_run_e12", S_RUN, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            check_b("b_run_hold", S_RUN, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
